// File: rtl/branch_unit_if.sv
// Branch issue / Branch CDB bundle between the branch reservation station,
// the branch unit and the CDB consumers.
interface branch_unit_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6
);
  // Issue side: Branch_valid is a one-cycle strobe with no back-pressure; the
  // RS stops issuing on Branch_almost_full. CDB side: an entry is consumed in
  // every cycle where Branch_cdb_valid and cdb_grant are both high (and rdy).
  logic              Branch_valid;
  logic [OP_W-1:0]   Branch_op;
  logic [DATA_W-1:0] Branch_reg1;
  logic [DATA_W-1:0] Branch_reg2;
  logic [TAG_W-1:0]  Branch_reg_des_rob;
  logic [DATA_W-1:0] Branch_imm;
  logic [DATA_W-1:0] Branch_pc;
  logic              cdb_grant;
  logic              Branch_cdb_valid;
  logic [TAG_W-1:0]  Branch_cdb_tag;
  logic [DATA_W-1:0] Branch_cdb_data;
  logic              Branch_cdb_taken;
  logic [DATA_W-1:0] Branch_cdb_target;
  logic              Branch_almost_full;

  modport master (
    output Branch_valid, Branch_op, Branch_reg1, Branch_reg2,
           Branch_reg_des_rob, Branch_imm, Branch_pc, cdb_grant,
    input  Branch_cdb_valid, Branch_cdb_tag, Branch_cdb_data,
           Branch_cdb_taken, Branch_cdb_target, Branch_almost_full
  );

  modport slave (
    input  Branch_valid, Branch_op, Branch_reg1, Branch_reg2,
           Branch_reg_des_rob, Branch_imm, Branch_pc, cdb_grant,
    output Branch_cdb_valid, Branch_cdb_tag, Branch_cdb_data,
           Branch_cdb_taken, Branch_cdb_target, Branch_almost_full
  );
endinterface

// File: rtl/branch_unit.sv
// Branch execution unit: resolves branch/jump direction, target and link value
// in one cycle and queues results for broadcast on the Branch CDB.
module branch_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6,
  parameter int QDEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clear,
  branch_unit_if.slave bus
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(8);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              taken;
    logic [DATA_W-1:0] target;
  } entry_t;

  entry_t            mem [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              known_op;
  logic              cond;
  logic [DATA_W-1:0] link;
  logic [DATA_W-1:0] pc_target;
  logic [DATA_W-1:0] jalr_sum;
  logic [DATA_W-1:0] target;
  entry_t            new_entry;
  entry_t            head;
  logic              full;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              drop;

  // Stage E: condition evaluation
  always_comb begin
    known_op = 1'b1;
    cond     = 1'b0;
    case (bus.Branch_op)
      OP_BEQ:  cond = (bus.Branch_reg1 == bus.Branch_reg2);
      OP_BNE:  cond = (bus.Branch_reg1 != bus.Branch_reg2);
      OP_BLT:  cond = ($signed(bus.Branch_reg1) <  $signed(bus.Branch_reg2));
      OP_BGE:  cond = ($signed(bus.Branch_reg1) >= $signed(bus.Branch_reg2));
      OP_BLTU: cond = (bus.Branch_reg1 <  bus.Branch_reg2);
      OP_BGEU: cond = (bus.Branch_reg1 >= bus.Branch_reg2);
      OP_JAL:  cond = 1'b1;
      OP_JALR: cond = 1'b1;
      default: known_op = 1'b0;
    endcase
  end

  assign link      = bus.Branch_pc + DATA_W'(4);
  assign pc_target = bus.Branch_pc + bus.Branch_imm;
  assign jalr_sum  = bus.Branch_reg1 + bus.Branch_imm;

  always_comb begin
    target = link;
    if (bus.Branch_op == OP_JALR) begin
      target = {jalr_sum[DATA_W-1:1], 1'b0};
    end else if (cond) begin
      target = pc_target;
    end
  end

  always_comb begin
    new_entry        = '0;
    new_entry.tag    = bus.Branch_reg_des_rob;
    new_entry.data   = link;
    new_entry.taken  = cond;
    new_entry.target = target;
  end

  assign full      = (count == CNT_W'(QDEPTH));
  assign not_empty = (count != '0);
  assign push      = rdy && !clear && bus.Branch_valid && known_op && !full;
  assign pop       = rdy && !clear && not_empty && bus.cdb_grant;
  assign drop      = rdy && !clear && bus.Branch_valid && known_op && full;

  // clear wins over rdy so a mispredict flush is never held off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    bus.Branch_cdb_valid  = not_empty;
    bus.Branch_cdb_tag    = '0;
    bus.Branch_cdb_data   = '0;
    bus.Branch_cdb_taken  = 1'b0;
    bus.Branch_cdb_target = '0;
    if (not_empty) begin
      bus.Branch_cdb_tag    = head.tag;
      bus.Branch_cdb_data   = head.data;
      bus.Branch_cdb_taken  = head.taken;
      bus.Branch_cdb_target = head.target;
    end
  end

  // not_empty term keeps the flag low out of reset even for QDEPTH == 2
  assign bus.Branch_almost_full = not_empty && (count >= CNT_W'(QDEPTH - 2));

  overflow_once : assert property (@(posedge clk) disable iff (!rst) !$rose(drop))
    else $error("branch_unit: result pushed into a full queue and dropped");

endmodule
